muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Iterative multiply/divide sequencer that owns the HI/LO register pair for the single-cycle datapath's `mult`, `div`, `mfhi` and `mflo` instructions. It latches operands from the register-file read ports (`srca`, `srcb`) and runs a 32-step shift-add multiply or restoring divide. It raises `stall` to freeze the PC while a dependent instruction waits, then presents HI or LO on a read port for the write-back mux.

## Interface
- `WIDTH`, 32, operand/result width; the iteration count equals `WIDTH`.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low (asserted at 0); sampled on the `clk` rising edge.
- `start_mult`  in  1  decoded `mult`, level, from the controller.
- `start_div`  in  1  decoded `div`, level.
- `signed_op`  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
- `rd_hi`  in  1  decoded `mfhi`.
- `rd_lo`  in  1  decoded `mflo`.
- `srca`  in  WIDTH  rs value: multiplicand or dividend.
- `srcb`  in  WIDTH  rt value: multiplier or divisor.
- `busy`  out  1  operation in flight.
- `stall`  out  1  freeze PC and instruction register this cycle.
- `done`  out  1  one-cycle pulse when HI/LO are updated.
- `div_zero`  out  1  last divide had divisor 0; holds until the next accepted start.
- `hilo_out`  out  WIDTH  HI if `rd_hi`, else LO; combinational.

## Operation
- States: IDLE, MUL, DIV, FIX.
- IDLE:
  - `start_mult` → MUL. Else `start_div` → DIV. `start_mult` has priority if both are high.
  - On accept: latch operand magnitudes (absolute values when `signed_op`=1, raw otherwise); latch result signs; clear the 5-bit step counter and `div_zero`.
  - Magnitude of 0x8000_0000 is 2^31 and fits unsigned.
- MUL: one shift-add step per cycle on a 2·WIDTH accumulator. After the step with counter = WIDTH−1 → FIX.
- DIV: one restoring step per cycle (shift remainder, trial-subtract, set quotient bit). After the step with counter = WIDTH−1 → FIX.
  - A zero divisor is detected at accept. The iteration still runs, giving constant latency.
- FIX: apply signs, write HI/LO, pulse `done`, → IDLE.
  - Product: negate the 64-bit magnitude if the operand signs differ. HI = upper word, LO = lower word.
  - Quotient sign = sign(a) XOR sign(b). Remainder takes the dividend's sign.
  - −2^31 / −1 (signed): LO = 0x8000_0000, HI = 0 (wraps, no trap).
  - Divisor 0: LO = 0xFFFF_FFFF, HI = latched raw `srca`, `div_zero`=1.
- `stall` = `busy` AND (`rd_hi` OR `rd_lo` OR `start_mult` OR `start_div`). Independent instructions proceed while busy.
- Start while busy: ignored. The stalled datapath re-presents the start, and it is accepted in the IDLE cycle after FIX.
- `hilo_out` is valid only when `busy`=0. During a busy cycle it shows the old HI/LO, and `stall` covers the read.
- `signed_op` and operands are ignored after accept.

## Timing
- Reset (`reset`=0 at an edge): state IDLE; HI = LO = 0; counter = 0; `busy`=0, `done`=0, `div_zero`=0, `stall`=0. Reset mid-operation aborts it and the partial result is discarded.
- Start accepted at edge E0. `busy`=1 from after E0 until after E33.
- Edges E1..E32 perform iteration steps 0..31. At E32, FIX is entered.
- Edge E33: HI/LO written, `busy`→0, `done`=1 for exactly the cycle after E33.
- Latency: results readable, with no stall, in the cycle after E33. That is 33 cycles after the accept cycle.
- Back-to-back: a start held since the busy period is accepted at E34. Throughput is one operation per 34 cycles.
- `stall` is combinational from the inputs and `busy`; no registered delay.

## Test plan
- Unsigned mult 7 × 6: `done` in the cycle after E33, then `rd_lo` gives 0x0000_002A and `rd_hi` gives 0. `busy` stays high for exactly 33 cycles.
- Signed mult −3 × 5 gives HI 0xFFFF_FFFF, LO 0xFFFF_FFF1. Unsigned 0xFFFF_FFFF × 0xFFFF_FFFF gives HI 0xFFFF_FFFE, LO 0x0000_0001.
- Signed div −7 / 2 gives LO 0xFFFF_FFFD, HI 0xFFFF_FFFF. Signed −2^31 / −1 gives LO 0x8000_0000, HI 0.
- Div 100 / 0 gives LO 0xFFFF_FFFF, HI 0x0000_0064, `div_zero`=1. A following `mult` start clears `div_zero`.
- Hazards:
  - `rd_lo` asserted the cycle after accept: `stall`=1 every cycle until `busy` falls, then `hilo_out` shows the new LO.
  - A non-HI/LO instruction during busy: `stall`=0.
  - A second start while busy is accepted at E34.
- Reset: `reset`=0 at step 10 of a divide returns IDLE next cycle with HI = LO = 0 and no `done` pulse. Simultaneous `start_mult` and `start_div` enter MUL.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide sequencer owning the HI/LO pair: 32-step shift-add
// multiply or restoring divide, with stall generation for dependent instructions.
module muldiv_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_mult,
   input  logic             start_div,
   input  logic             signed_op,
   input  logic             rd_hi,
   input  logic             rd_lo,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hilo_out
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      FIX  = 2'd3
   } state_t;

   state_t               state_r;
   logic [2*WIDTH-1:0]   acc_r;
   logic [WIDTH-1:0]     a_mag_r;
   logic [WIDTH-1:0]     b_mag_r;
   logic [WIDTH-1:0]     a_raw_r;
   logic [WIDTH-1:0]     hi_r;
   logic [WIDTH-1:0]     lo_r;
   logic [CW-1:0]        cnt_r;
   logic                 neg_res_r;
   logic                 neg_rem_r;
   logic                 is_div_r;
   logic                 zero_div_r;
   logic                 busy_r;
   logic                 done_r;
   logic                 div_zero_r;

   logic                 a_neg_s;
   logic                 b_neg_s;
   logic [WIDTH-1:0]     a_abs_s;
   logic [WIDTH-1:0]     b_abs_s;
   logic [WIDTH:0]       mul_sum_s;
   logic [2*WIDTH-1:0]   mul_next_s;
   logic [WIDTH:0]       div_shift_s;
   logic [WIDTH:0]       div_diff_s;
   logic [2*WIDTH-1:0]   div_next_s;
   logic [WIDTH-1:0]     fix_hi_s;
   logic [WIDTH-1:0]     fix_lo_s;
   logic [2*WIDTH-1:0]   prod_neg_s;

   // Operand magnitudes and signs as seen at the accept edge.
   always_comb begin
      a_neg_s = signed_op & srca[WIDTH-1];
      b_neg_s = signed_op & srcb[WIDTH-1];
      a_abs_s = srca;
      b_abs_s = srcb;
      if (a_neg_s) begin
         a_abs_s = {WIDTH{1'b0}} - srca;
      end else begin
         a_abs_s = srca;
      end
      if (b_neg_s) begin
         b_abs_s = {WIDTH{1'b0}} - srcb;
      end else begin
         b_abs_s = srcb;
      end
   end

   // One multiply step: add multiplicand to the upper half when the LSB is set, then shift right.
   always_comb begin
      mul_sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
      if (acc_r[0]) begin
         mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, a_mag_r};
      end else begin
         mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
      end
      mul_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};
   end

   // One restoring divide step: acc holds {remainder, dividend/quotient}.
   always_comb begin
      div_shift_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
      div_diff_s  = div_shift_s - {1'b0, b_mag_r};
      div_next_s  = {div_shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
      if (div_shift_s >= {1'b0, b_mag_r}) begin
         div_next_s = {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
      end else begin
         div_next_s = {div_shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
      end
   end

   // Sign fix-up of the finished magnitude into the HI/LO values to be written.
   always_comb begin
      prod_neg_s = {(2*WIDTH){1'b0}} - acc_r;
      fix_hi_s   = hi_r;
      fix_lo_s   = lo_r;
      if (is_div_r) begin
         if (zero_div_r) begin
            fix_lo_s = {WIDTH{1'b1}};
            fix_hi_s = a_raw_r;
         end else begin
            if (neg_res_r) begin
               fix_lo_s = {WIDTH{1'b0}} - acc_r[WIDTH-1:0];
            end else begin
               fix_lo_s = acc_r[WIDTH-1:0];
            end
            if (neg_rem_r) begin
               fix_hi_s = {WIDTH{1'b0}} - acc_r[2*WIDTH-1:WIDTH];
            end else begin
               fix_hi_s = acc_r[2*WIDTH-1:WIDTH];
            end
         end
      end else begin
         if (neg_res_r) begin
            {fix_hi_s, fix_lo_s} = prod_neg_s;
         end else begin
            {fix_hi_s, fix_lo_s} = acc_r;
         end
      end
   end

   // Sequencer FSM with its datapath registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r    <= IDLE;
         acc_r      <= {(2*WIDTH){1'b0}};
         a_mag_r    <= {WIDTH{1'b0}};
         b_mag_r    <= {WIDTH{1'b0}};
         a_raw_r    <= {WIDTH{1'b0}};
         hi_r       <= {WIDTH{1'b0}};
         lo_r       <= {WIDTH{1'b0}};
         cnt_r      <= {CW{1'b0}};
         neg_res_r  <= 1'b0;
         neg_rem_r  <= 1'b0;
         is_div_r   <= 1'b0;
         zero_div_r <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         div_zero_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               done_r <= 1'b0;
               if (start_mult || start_div) begin
                  state_r    <= start_mult ? MUL : DIV;
                  is_div_r   <= ~start_mult;
                  a_mag_r    <= a_abs_s;
                  b_mag_r    <= b_abs_s;
                  a_raw_r    <= srca;
                  neg_res_r  <= a_neg_s ^ b_neg_s;
                  neg_rem_r  <= a_neg_s;
                  zero_div_r <= ~start_mult & (srcb == {WIDTH{1'b0}});
                  cnt_r      <= {CW{1'b0}};
                  div_zero_r <= 1'b0;
                  busy_r     <= 1'b1;
                  // Multiply shifts the multiplier out of the low half; divide shifts the dividend.
                  if (start_mult) begin
                     acc_r <= {{WIDTH{1'b0}}, b_abs_s};
                  end else begin
                     acc_r <= {{WIDTH{1'b0}}, a_abs_s};
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            MUL: begin
               acc_r <= mul_next_s;
               cnt_r <= cnt_r + CW'(1);
               if (cnt_r == CW'(WIDTH - 1)) begin
                  state_r <= FIX;
               end else begin
                  state_r <= MUL;
               end
            end
            DIV: begin
               acc_r <= div_next_s;
               cnt_r <= cnt_r + CW'(1);
               if (cnt_r == CW'(WIDTH - 1)) begin
                  state_r <= FIX;
               end else begin
                  state_r <= DIV;
               end
            end
            FIX: begin
               hi_r       <= fix_hi_s;
               lo_r       <= fix_lo_s;
               div_zero_r <= zero_div_r;
               busy_r     <= 1'b0;
               done_r     <= 1'b1;
               state_r    <= IDLE;
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

   assign busy     = busy_r;
   assign done     = done_r;
   assign div_zero = div_zero_r;
   assign stall    = busy_r & (rd_hi | rd_lo | start_mult | start_div);
   assign hilo_out = rd_hi ? hi_r : lo_r;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer: arithmetic results,
// latency, hazards/stall, back-to-back acceptance and mid-operation reset.
module tb_muldiv_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start_mult;
   logic        start_div;
   logic        signed_op;
   logic        rd_hi;
   logic        rd_lo;
   logic [31:0] srca;
   logic [31:0] srcb;
   logic        busy;
   logic        stall;
   logic        done;
   logic        div_zero;
   logic [31:0] hilo_out;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   muldiv_sequencer #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start_mult(start_mult), .start_div(start_div),
      .signed_op(signed_op), .rd_hi(rd_hi), .rd_lo(rd_lo), .srca(srca), .srcb(srcb),
      .busy(busy), .stall(stall), .done(done), .div_zero(div_zero), .hilo_out(hilo_out)
   );

   // Pulse a start for one cycle, scramble operands afterwards, wait (bounded) for done.
   task automatic run_op(input logic is_div, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, output int busy_cycles, output bit got_done);
      @(negedge clk);
      start_mult = ~is_div; start_div = is_div; signed_op = sgn; srca = a; srcb = b;
      @(negedge clk);
      start_mult = 1'b0; start_div = 1'b0; signed_op = ~sgn;
      srca = 32'hDEAD_BEEF; srcb = 32'h1234_5678;
      busy_cycles = 0; got_done = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (!got_done) begin
            if (done) begin
               got_done = 1'b1;
            end else begin
               if (busy) busy_cycles++;
               @(negedge clk);
            end
         end
      end
   endtask

   task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
      rd_hi = 1'b0; rd_lo = 1'b1; #1; lo = hilo_out;
      rd_hi = 1'b1; rd_lo = 1'b0; #1; hi = hilo_out;
      rd_hi = 1'b0;
   endtask

   task automatic test_reset;
      logic [31:0] hi, lo;
      reset = 1'b0; start_mult = 1'b0; start_div = 1'b0; signed_op = 1'b0;
      rd_hi = 1'b0; rd_lo = 1'b0; srca = 32'd0; srcb = 32'd0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({busy, done, div_zero, stall} !== 4'b0000) begin
         n_err++; $display("FAIL reset_flags: got %b expected 0000", {busy, done, div_zero, stall});
      end
      read_hilo(hi, lo);
      n_cmp++;
      if ({hi, lo} !== 64'd0) begin
         n_err++; $display("FAIL reset_hilo: got %h expected 0", {hi, lo});
      end
      reset = 1'b1;
   endtask

   task automatic test_op(input string name, input logic is_div, input logic sgn,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int bc; bit gd; logic [31:0] hi, lo;
      run_op(is_div, sgn, a, b, bc, gd);
      n_cmp++;
      if (!gd) begin
         n_err++; $display("FAIL %s_done: no done pulse within bound", name);
      end
      n_cmp++;
      if (bc !== 33) begin
         n_err++; $display("FAIL %s_busy_cycles: got %0d expected 33", name, bc);
      end
      read_hilo(hi, lo);
      n_cmp++;
      if (lo !== exp_lo) begin
         n_err++; $display("FAIL %s_lo: got %h expected %h", name, lo, exp_lo);
      end
      n_cmp++;
      if (hi !== exp_hi) begin
         n_err++; $display("FAIL %s_hi: got %h expected %h", name, hi, exp_hi);
      end
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0) begin
         n_err++; $display("FAIL %s_done_width: got %b expected 0", name, done);
      end
   endtask

   task automatic test_mult;
      test_op("mulu_7x6", 1'b0, 1'b0, 32'd7, 32'd6, 32'h0000_0000, 32'h0000_002A);
      test_op("muls_m3x5", 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
      test_op("mulu_max", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
   endtask

   task automatic test_div;
      test_op("divs_m7d2", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      test_op("divs_min", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
      test_op("divu_100d7", 1'b1, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14);
   endtask

   task automatic test_div_zero;
      int bc; bit gd;
      test_op("div_by_0", 1'b1, 1'b0, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF);
      n_cmp++;
      if (div_zero !== 1'b1) begin
         n_err++; $display("FAIL div_zero_set: got %b expected 1", div_zero);
      end
      run_op(1'b0, 1'b0, 32'd2, 32'd3, bc, gd);
      n_cmp++;
      if (div_zero !== 1'b0) begin
         n_err++; $display("FAIL div_zero_clear: got %b expected 0", div_zero);
      end
   endtask

   task automatic test_hazard;
      int cyc; bit bad; logic [31:0] hi, lo;
      @(negedge clk);
      start_mult = 1'b1; signed_op = 1'b0; srca = 32'd9; srcb = 32'd9;
      @(negedge clk);
      start_mult = 1'b0; rd_lo = 1'b1; #1;
      cyc = 0; bad = 1'b0;
      while (busy && cyc < 100) begin
         if (stall !== 1'b1) bad = 1'b1;
         cyc++;
         @(negedge clk); #1;
      end
      n_cmp++;
      if (bad || cyc !== 33) begin
         n_err++; $display("FAIL hazard_stall: stall_dropped=%b busy_cycles=%0d expected 0/33", bad, cyc);
      end
      n_cmp++;
      if (stall !== 1'b0 || hilo_out !== 32'd81) begin
         n_err++; $display("FAIL hazard_read: stall=%b lo=%h expected 0/00000051", stall, hilo_out);
      end
      rd_lo = 1'b0;
      // Independent instruction during busy does not stall; HI read does.
      @(negedge clk);
      start_mult = 1'b1; srca = 32'd2; srcb = 32'd2;
      @(negedge clk);
      start_mult = 1'b0; #1;
      n_cmp++;
      if (busy !== 1'b1 || stall !== 1'b0) begin
         n_err++; $display("FAIL indep_nostall: busy=%b stall=%b expected 1/0", busy, stall);
      end
      rd_hi = 1'b1; #1;
      n_cmp++;
      if (stall !== 1'b1) begin
         n_err++; $display("FAIL rdhi_stall: got %b expected 1", stall);
      end
      rd_hi = 1'b0; start_div = 1'b1; #1;
      n_cmp++;
      if (stall !== 1'b1) begin
         n_err++; $display("FAIL start_stall: got %b expected 1", stall);
      end
      start_div = 1'b0;
      cyc = 0;
      while (!done && cyc < 100) begin
         cyc++; @(negedge clk);
      end
      read_hilo(hi, lo);
      n_cmp++;
      if (lo !== 32'd4) begin
         n_err++; $display("FAIL ignored_start_lo: got %h expected 00000004", lo);
      end
   endtask

   task automatic test_back_to_back;
      int cyc; bit gd; logic [31:0] hi, lo;
      @(negedge clk);
      start_mult = 1'b1; signed_op = 1'b0; srca = 32'd3; srcb = 32'd4;
      @(negedge clk);
      srca = 32'd5; srcb = 32'd6;
      cyc = 0;
      while (!done && cyc < 100) begin
         cyc++; @(negedge clk);
      end
      n_cmp++;
      if (cyc !== 33 || busy !== 1'b0) begin
         n_err++; $display("FAIL b2b_first_done: cycles=%0d busy=%b expected 33/0", cyc, busy);
      end
      rd_lo = 1'b1; #1;
      n_cmp++;
      if (hilo_out !== 32'd12) begin
         n_err++; $display("FAIL b2b_first_lo: got %h expected 0000000c", hilo_out);
      end
      rd_lo = 1'b0;
      @(negedge clk);
      start_mult = 1'b0;
      n_cmp++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         n_err++; $display("FAIL b2b_accept_e34: busy=%b done=%b expected 1/0", busy, done);
      end
      gd = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (!gd) begin
            if (done) gd = 1'b1;
            else @(negedge clk);
         end
      end
      read_hilo(hi, lo);
      n_cmp++;
      if (!gd || lo !== 32'd30) begin
         n_err++; $display("FAIL b2b_second_lo: done=%b lo=%h expected 1/0000001e", gd, lo);
      end
   endtask

   task automatic test_reset_mid;
      int dones; logic [31:0] hi, lo;
      @(negedge clk);
      start_div = 1'b1; signed_op = 1'b0; srca = 32'd50; srcb = 32'd3;
      @(negedge clk);
      start_div = 1'b0;
      repeat (10) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_err++; $display("FAIL midreset_idle: busy=%b done=%b expected 0/0", busy, done);
      end
      read_hilo(hi, lo);
      n_cmp++;
      if ({hi, lo} !== 64'd0) begin
         n_err++; $display("FAIL midreset_hilo: got %h expected 0", {hi, lo});
      end
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done || busy) dones++;
      end
      n_cmp++;
      if (dones !== 0) begin
         n_err++; $display("FAIL midreset_no_done: got %0d active cycles expected 0", dones);
      end
   endtask

   task automatic test_priority;
      int cyc; logic [31:0] hi, lo;
      @(negedge clk);
      start_mult = 1'b1; start_div = 1'b1; signed_op = 1'b0; srca = 32'd6; srcb = 32'd3;
      @(negedge clk);
      start_mult = 1'b0; start_div = 1'b0;
      cyc = 0;
      while (!done && cyc < 100) begin
         cyc++; @(negedge clk);
      end
      read_hilo(hi, lo);
      n_cmp++;
      if (lo !== 32'd18 || hi !== 32'd0) begin
         n_err++; $display("FAIL priority_mult: hi=%h lo=%h expected 00000000/00000012", hi, lo);
      end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_div_zero();
      test_hazard();
      test_back_to_back();
      test_reset_mid();
      test_priority();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
